// File: rtl/tqvp_uart_pkg.sv
// tqvp_uart_pkg: shared constants and types for the buffered TinyQV UART.
//   - register addresses inside the 16-byte window
//   - STATUS / CTRL bit positions
//   - TX / RX state encodings
//   - minimum legal baud divisor and the clamp helper that enforces it
package tqvp_uart_pkg;

    localparam logic [3:0] ADDR_DATA     = 4'h0;
    localparam logic [3:0] ADDR_STATUS   = 4'h1;
    localparam logic [3:0] ADDR_CTRL     = 4'h2;
    localparam logic [3:0] ADDR_DIV_LO   = 4'h3;
    localparam logic [3:0] ADDR_DIV_HI   = 4'h4;
    localparam logic [3:0] ADDR_RX_COUNT = 4'h5;
    localparam logic [3:0] ADDR_TX_COUNT = 4'h6;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TX_ACTIVE   = 4;
    localparam int ST_RX_OVR      = 5;
    localparam int ST_FRAME_ERR   = 6;
    localparam int ST_TX_OVF      = 7;

    localparam int CTRL_POP      = 0;
    localparam int CTRL_FLUSH_RX = 1;
    localparam int CTRL_FLUSH_TX = 2;
    localparam int CTRL_LOOPBACK = 3;

    localparam logic [15:0] DIV_MIN = 16'd7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Divisors below DIV_MIN leave too few cycles per bit for mid-bit sampling.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/tqvp_uart_sync_fifo.sv
// tqvp_uart_sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write; accepted when not full, or when full with an accepted pop
//   pop        : drop the head; ignored when empty
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   dout       : current head (undefined content when empty)
//   count      : occupancy 0..DEPTH; full / empty flags
module tqvp_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push lands in, so full+push+pop works.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tqvp_uart_buffered.sv
// tqvp_uart_buffered: TinyQV peripheral, full-duplex 8N1 UART with RX/TX FIFOs,
// programmable divisor (bit period DIV+1 cycles), sticky error flags, loopback.
//   clk, rst_n           : clock, synchronous active-low reset
//   ui_in[7]             : RX line (already synchronised)
//   uo_out               : {6'b0, rx_nonempty, tx}
//   address, data_write, data_in : register write port (one-cycle strobe)
//   data_out             : combinational register read
module tqvp_uart_buffered
    import tqvp_uart_pkg::*;
#(
    parameter int CLK_HZ       = 64000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / DEFAULT_BAUD - 1);

    // ---------------- register strobes ----------------
    logic wr_data, wr_status, wr_ctrl, wr_div_lo, wr_div_hi;
    assign wr_data   = data_write && (address == ADDR_DATA);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_div_lo = data_write && (address == ADDR_DIV_LO);
    assign wr_div_hi = data_write && (address == ADDR_DIV_HI);

    logic rx_pop, rx_flush, tx_flush;
    assign rx_pop   = wr_ctrl && data_in[CTRL_POP];
    assign rx_flush = wr_ctrl && data_in[CTRL_FLUSH_RX];
    assign tx_flush = wr_ctrl && data_in[CTRL_FLUSH_TX];

    // ---------------- FIFOs ----------------
    logic                        tx_pop, tx_full, tx_empty;
    logic [7:0]                  tx_dout;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic                        rx_full, rx_empty;
    logic [7:0]                  rx_dout;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        rx_push_q, rx_push_d;
    logic [7:0]                  rx_shift_q, rx_shift_d;

    tqvp_uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_data), .pop(tx_pop), .flush(tx_flush),
        .din(data_in), .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    tqvp_uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_q), .pop(rx_pop), .flush(rx_flush),
        .din(rx_shift_q), .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- config / sticky state ----------------
    logic [15:0] div_q, div_d;
    logic        loopback_q, loopback_d;
    logic        rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;
    logic        rx_ovr_set, frame_err_set, tx_ovf_set;

    // Overflow only when the FIFO really refuses the byte; flush swallows it silently.
    assign tx_ovf_set = wr_data && tx_full && !tx_pop && !tx_flush;
    assign rx_ovr_set = rx_push_q && rx_full && !rx_pop && !rx_flush;

    always_comb begin
        div_d      = div_q;
        loopback_d = loopback_q;
        if (wr_div_lo) div_d = clamp_div({div_q[15:8], data_in});
        if (wr_div_hi) div_d = clamp_div({data_in, div_q[7:0]});
        if (wr_ctrl)   loopback_d = data_in[CTRL_LOOPBACK];
        // set wins over write-1-to-clear
        rx_ovr_d    = (rx_ovr_q    & ~(wr_status & data_in[ST_RX_OVR]))    | rx_ovr_set;
        frame_err_d = (frame_err_q & ~(wr_status & data_in[ST_FRAME_ERR])) | frame_err_set;
        tx_ovf_d    = (tx_ovf_q    & ~(wr_status & data_in[ST_TX_OVF]))    | tx_ovf_set;
    end

    // ---------------- TX FSM ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_bit_end, tx_load;

    assign tx_bit_end = (tx_cnt_q == tx_div_q);
    // Do not launch a byte that is being flushed this very cycle.
    assign tx_load    = !tx_empty && !tx_flush;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_div_d   = div_q;
                    tx_data_d  = tx_dout;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end
            TX_STOP: if (tx_bit_end) begin
                // chain straight into the next frame: no idle gap
                if (tx_load) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_div_d   = div_q;
                    tx_data_d  = tx_dout;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level is registered from the current state, so it trails the
        // state by one cycle while keeping every bit exactly DIV+1 long.
        case (tx_state_q)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_data_q[tx_bit_q];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_prev_q;
    logic        rx_in;

    assign rx_in = loopback_q ? tx_line_q : ui_in[7];

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q + 16'd1;
        rx_div_d      = rx_div_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push_d     = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_in) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_q;
                end
            end
            RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
                rx_cnt_d = '0;
                if (rx_in) rx_state_d = RX_IDLE;   // glitch, not a start bit
                else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = 3'd0;
                end
            end
            RX_DATA: if (rx_cnt_q == rx_div_q) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_in, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            RX_STOP: if (rx_cnt_q == rx_div_q) begin
                rx_cnt_d = '0;
                if (rx_in) begin
                    rx_push_d  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_err_set = 1'b1;
                    rx_state_d    = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_in) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= DIV_RESET;
            loopback_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= DIV_RESET;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            tx_line_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= DIV_RESET;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_push_q   <= 1'b0;
            rx_prev_q   <= 1'b1;
        end else begin
            div_q       <= div_d;
            loopback_q  <= loopback_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_ovf_q    <= tx_ovf_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_line_q   <= tx_line_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_push_q   <= rx_push_d;
            rx_prev_q   <= rx_in;
        end
    end

    // ---------------- outputs ----------------
    logic [7:0] status;
    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_ACTIVE]   = (tx_state_q != TX_IDLE);
        status[ST_RX_OVR]      = rx_ovr_q;
        status[ST_FRAME_ERR]   = frame_err_q;
        status[ST_TX_OVF]      = tx_ovf_q;
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_DATA:     data_out = rx_empty ? 8'h00 : rx_dout;
            ADDR_STATUS:   data_out = status;
            ADDR_CTRL:     data_out = {4'b0, loopback_q, 3'b0};
            ADDR_DIV_LO:   data_out = div_q[7:0];
            ADDR_DIV_HI:   data_out = div_q[15:8];
            ADDR_RX_COUNT: data_out = 8'(rx_count);
            ADDR_TX_COUNT: data_out = 8'(tx_count);
            default:       data_out = 8'h00;
        endcase
    end

    assign uo_out = {6'b0, !rx_empty, loopback_q ? 1'b1 : tx_line_q};

    logic unused_ui;
    assign unused_ui = &{1'b0, ui_in[6:0]};

endmodule

// File: tb/tb_tqvp_uart_buffered.sv
// Scoreboard bench for tqvp_uart_buffered: stimulus pushes expected register
// values and expected TX bytes into queues; separate monitors compare them.
module tb_tqvp_uart_buffered;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h80;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    tqvp_uart_buffered dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;    // 0: data_out, 1: uo_out
        logic [7:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] tx_exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         tx_mon_en = 1'b0;
    event       chk_ev;

    // register/pin monitor
    initial begin
        chk_t       cur;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (chk_q.size() != 0) begin
                cur = chk_q.pop_front();
                act = cur.sel ? uo_out : data_out;
                checks++;
                if (act !== cur.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h, expected 0x%02h", cur.name, act, cur.exp);
                end
            end
        end
    end

    // TX line monitor: captures a whole 80-cycle frame (DIV=7) and checks shape and byte
    initial begin
        logic        prev;
        logic [79:0] samp;
        logic [7:0]  got, want;
        logic [9:0]  fr;
        bit          bad;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev && !uo_out[0]) begin
                samp[0] = uo_out[0];
                for (int c = 1; c < 80; c++) begin
                    @(negedge clk);
                    samp[c] = uo_out[0];
                end
                for (int k = 0; k < 8; k++) got[k] = samp[8*(k+1)+4];
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_frame: unexpected byte 0x%02h", got);
                end else begin
                    want = tx_exp_q.pop_front();
                    fr   = {1'b1, want, 1'b0};
                    bad  = 1'b0;
                    for (int c = 0; c < 80; c++) if (samp[c] !== fr[c/8]) bad = 1'b1;
                    if (bad || got !== want) begin
                        errors++;
                        $display("FAIL tx_frame: got 0x%02h (shape_bad=%0d), expected 0x%02h", got, bad, want);
                    end
                end
                prev = samp[79];
            end else begin
                prev = uo_out[0];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] a, input logic [7:0] e);
        address = a;
        #1;
        chk_q.push_back('{name, 1'b0, e});
        ->chk_ev;
        #1;
    endtask

    task automatic chk_uo(input string name, input logic [7:0] e);
        chk_q.push_back('{name, 1'b1, e});
        ->chk_ev;
        #1;
    endtask

    // External 8N1 frame at 8 cycles/bit; optionally a CTRL pop on the push edge.
    task automatic rx_frame(input logic [7:0] b, input logic stop_b, input bit pop_at_push);
        logic [9:0] bits;
        bits = {stop_b, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            ui_in[7] = bits[j];
            for (int i = 0; i < 8; i++) begin
                if (pop_at_push && j == 9 && i == 5) begin
                    address    = 4'h2;
                    data_in    = 8'h01;
                    data_write = 1'b1;
                end
                tick();
                data_write = 1'b0;
            end
        end
        ui_in[7] = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_status", 4'h1, 8'h04);
        chk("rst_div_lo", 4'h3, 8'h2A);
        chk("rst_div_hi", 4'h4, 8'h02);
        chk_uo("rst_uo", 8'h01);
        tick();
        chk("rst_ctrl", 4'h2, 8'h00);
        chk("rst_rx_count", 4'h5, 8'h00);
        chk("rst_data", 4'h0, 8'h00);
        chk("unmapped", 4'h9, 8'h00);
        tick();

        // divisor clamp
        wr(4'h4, 8'h00);
        wr(4'h3, 8'h03);
        chk("div_clamp", 4'h3, 8'h07);
        chk("div_hi", 4'h4, 8'h00);
        tick();

        // TX latency and frame
        tx_mon_en = 1'b1;
        tx_exp_q.push_back(8'h5A);
        wr(4'h0, 8'h5A);
        chk_uo("tx_after_n", 8'h01);
        tick();
        chk_uo("tx_after_n1", 8'h01);
        tick();
        chk_uo("tx_after_n2", 8'h00);
        chk("tx_active", 4'h1, 8'h14);
        repeat (85) tick();
        chk("tx_done", 4'h1, 8'h04);
        tick();

        // loopback
        wr(4'h2, 8'h08);
        chk("ctrl_lb", 4'h2, 8'h08);
        chk_uo("lb_uo", 8'h01);
        tick();
        wr(4'h0, 8'hA5);
        wr(4'h0, 8'h3C);
        repeat (200) tick();
        chk("lb_rx_count", 4'h5, 8'h02);
        chk_uo("lb_uo_nonempty", 8'h03);
        chk("lb_head0", 4'h0, 8'hA5);
        tick();
        wr(4'h2, 8'h09);
        chk("lb_head1", 4'h0, 8'h3C);
        chk("lb_count1", 4'h5, 8'h01);
        tick();
        wr(4'h2, 8'h09);
        chk("lb_count0", 4'h5, 8'h00);
        chk("lb_empty_data", 4'h0, 8'h00);
        tick();
        wr(4'h2, 8'h09);
        chk("pop_empty", 4'h5, 8'h00);
        wr(4'h2, 8'h00);

        // TX overflow
        tx_exp_q.push_back(8'h11);
        wr(4'h0, 8'h11);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_exp_q.push_back(8'(32 + i));
            wr(4'h0, 8'(32 + i));
        end
        chk("tx_count_full", 4'h6, 8'h10);
        chk("tx_ovf_status", 4'h1, 8'h98);
        tick();
        wr(4'h1, 8'h80);
        chk("tx_ovf_w1c", 4'h1, 8'h18);
        for (int i = 0; i < 2000 && tx_exp_q.size() != 0; i++) tick();
        checks++;
        if (tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL tx_drain: %0d frames outstanding, expected 0", tx_exp_q.size());
        end
        repeat (5) tick();
        chk("tx_drained", 4'h1, 8'h04);
        tick();

        // framing error and glitch
        rx_frame(8'h55, 1'b0, 1'b0);
        repeat (4) tick();
        chk("frame_err", 4'h1, 8'h44);
        chk("ferr_count", 4'h5, 8'h00);
        tick();
        wr(4'h1, 8'h40);
        chk("ferr_w1c", 4'h1, 8'h04);
        tick();
        ui_in[7] = 1'b0;
        tick();
        tick();
        ui_in[7] = 1'b1;
        repeat (12) tick();
        chk("glitch_status", 4'h1, 8'h04);
        chk("glitch_count", 4'h5, 8'h00);
        tick();
        rx_frame(8'hC3, 1'b1, 1'b0);
        repeat (3) tick();
        chk("rx_good_count", 4'h5, 8'h01);
        chk("rx_good_data", 4'h0, 8'hC3);
        chk_uo("rx_good_uo", 8'h03);
        tick();
        wr(4'h2, 8'h02);
        chk("rx_flush_count", 4'h5, 8'h00);
        chk_uo("rx_flush_uo", 8'h01);
        tick();

        // RX overflow
        for (int i = 0; i < 16; i++) rx_frame(8'(8'h40 + i), 1'b1, 1'b0);
        repeat (3) tick();
        chk("rx_fill_count", 4'h5, 8'h10);
        chk("rx_fill_status", 4'h1, 8'h07);
        tick();
        rx_frame(8'h77, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rx_pushpop_count", 4'h5, 8'h10);
        chk("rx_pushpop_status", 4'h1, 8'h07);
        chk("rx_pushpop_head", 4'h0, 8'h41);
        tick();
        rx_frame(8'h78, 1'b1, 1'b0);
        repeat (3) tick();
        chk("rx_ovr_count", 4'h5, 8'h10);
        chk("rx_ovr_status", 4'h1, 8'h27);
        tick();
        wr(4'h1, 8'h20);
        chk("rx_ovr_w1c", 4'h1, 8'h07);
        tick();

        // reset mid-frame
        tx_mon_en = 1'b0;
        wr(4'h0, 8'hF0);
        repeat (10) tick();
        chk_uo("mid_frame_low", 8'h02);
        tick();
        rst_n = 1'b0;
        tick();
        chk_uo("rst_mid_uo", 8'h01);
        chk("rst_mid_status", 4'h1, 8'h04);
        chk("rst_mid_div", 4'h3, 8'h2A);
        rst_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
